fu_cdb_arbiter: RTL and testbench
=================================

FU_CDB_ARBITER -- requirements
Module: fu_cdb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data/address width in bits.
REQ-002 Parameter ROB, default 3, ROB tag width in bits.
REQ-003 Parameter N_ALU, default 2, number of ALU result channels (range 1..8).
REQ-004 Parameter DEPTH, default 2, per-ALU result queue depth (power of two, >=2).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 flush  in  1  pipeline flush; discards all buffered results.
REQ-008 alu_valid  in  N_ALU  per-channel result valid.
REQ-009 alu_result  in  N_ALU*WIDTH  per-channel result; channel i at bits [i*WIDTH +: WIDTH].
REQ-010 alu_rob  in  N_ALU*ROB  per-channel ROB tag; channel i at [i*ROB +: ROB].
REQ-011 alu_available  out  N_ALU  channel i queue can accept a result this cycle.
REQ-012 br_valid  in  1  branch result valid.
REQ-013 br_result  in  WIDTH  branch link value.
REQ-014 br_rob  in  ROB  branch ROB tag.
REQ-015 br_mispredict  in  1  branch resolved against prediction.
REQ-016 br_target  in  WIDTH  corrected fetch address.
REQ-017 br_available  out  1  branch slot empty.
REQ-018 cdb_valid  out  1  broadcast valid (registered).
REQ-019 cdb_data, cdb_rob  out  WIDTH, ROB  broadcast value and tag (registered).
REQ-020 cdb_redirect, cdb_redirect_pc  out  1, WIDTH  fetch redirect flag and address (registered).

Function
REQ-021 Each ALU channel SHALL own a DEPTH-entry FIFO of {result, tag}; branch SHALL own a 1-entry slot of {result, tag, mispredict, target}.
REQ-022 alu_available[i] SHALL be 1 iff queue i count < DEPTH; br_available SHALL be 1 iff slot empty; neither depends on same-cycle pops.
REQ-023 Push SHALL occur at an edge when valid and available are both 1; valid while not available SHALL be ignored without state change.
REQ-024 Exactly one entry at most SHALL be granted per cycle; the granted entry is popped and registered onto the CDB at the same edge.
REQ-025 Priority: nonempty branch slot SHALL win; otherwise round-robin among nonempty ALU queues starting at pointer rr.
REQ-026 rr SHALL update to (granted channel + 1) mod N_ALU on an ALU grant; unchanged on branch grant or no grant.
REQ-027 Minimum latency: result pushed at edge E SHALL appear on CDB outputs after edge E+1.
REQ-028 Push and pop on the same queue at one edge SHALL both take effect; count unchanged; FIFO order preserved; pointers wrap mod DEPTH.
REQ-029 With no grant, cdb_valid SHALL be 0 next cycle; cdb_data/cdb_rob/cdb_redirect_pc hold previous values; cdb_redirect SHALL be 0.
REQ-030 cdb_redirect SHALL be 1 only in the cycle broadcasting a branch entry with mispredict=1; cdb_redirect_pc = that entry's target.
REQ-031 Non-mispredicted branch grant SHALL drive cdb_valid=1, cdb_redirect=0, cdb_data=br_result, cdb_rob=br_rob.
REQ-032 flush SHALL, at the edge, empty all queues and the branch slot, ignore same-edge pushes, and set cdb_valid and cdb_redirect to 0; rr retained.
REQ-033 The block SHALL NOT generate flush from cdb_redirect; flush is external.

Reset
REQ-034 reset SHALL immediately empty all queues and the branch slot, set rr=0, and clear cdb_valid, cdb_redirect, cdb_data, cdb_rob, cdb_redirect_pc to 0.
REQ-035 During reset alu_available SHALL be all ones and br_available 1; reset asserted mid-burst SHALL lose all buffered entries.

Verification
REQ-036 Single push: alu_valid=01, result 0x11, tag 2 at edge 1 -> cdb_valid=1, cdb_data=0x11, cdb_rob=2 after edge 2, then 0.
REQ-037 Contention: both ALU channels and branch push same edge -> broadcast order branch, ALU0, ALU1 on three consecutive cycles.
REQ-038 Fairness: both ALU channels push every cycle -> grants alternate 0,1,0,1; no channel starved.
REQ-039 Full queue: channel 0 pushes DEPTH entries while branch occupies CDB -> alu_available[0]=0; extra push dropped; DEPTH entries drain in order.
REQ-040 Mispredict: br_mispredict=1, br_target=0x400 -> one cycle cdb_redirect=1, cdb_redirect_pc=0x400; then flush with entries queued -> cdb_valid=0, all available=1.
REQ-041 Async reset asserted between edges with full queues -> outputs 0 immediately, no broadcasts after release until new pushes.

Source files
------------

// File: rtl/fu_cdb_arbiter.sv
// Common data bus arbiter: per-ALU result FIFOs plus a one-entry branch slot,
// one registered broadcast per cycle with branch priority and ALU round-robin.
module fu_cdb_arbiter #(
  parameter int WIDTH = 32,
  parameter int ROB   = 3,
  parameter int N_ALU = 2,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [N_ALU-1:0]       alu_valid,
  input  logic [N_ALU*WIDTH-1:0] alu_result,
  input  logic [N_ALU*ROB-1:0]   alu_rob,
  output logic [N_ALU-1:0]       alu_available,
  input  logic                   br_valid,
  input  logic [WIDTH-1:0]       br_result,
  input  logic [ROB-1:0]         br_rob,
  input  logic                   br_mispredict,
  input  logic [WIDTH-1:0]       br_target,
  output logic                   br_available,
  output logic                   cdb_valid,
  output logic [WIDTH-1:0]       cdb_data,
  output logic [ROB-1:0]         cdb_rob,
  output logic                   cdb_redirect,
  output logic [WIDTH-1:0]       cdb_redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (N_ALU > 1) ? $clog2(N_ALU) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW:0]   N_ALU_C = (IW + 1)'(N_ALU);
  localparam logic [IW-1:0] LAST_C  = IW'(N_ALU - 1);

  logic [WIDTH-1:0] qdata_q [N_ALU][DEPTH];
  logic [WIDTH-1:0] qdata_d [N_ALU][DEPTH];
  logic [ROB-1:0]   qrob_q  [N_ALU][DEPTH];
  logic [ROB-1:0]   qrob_d  [N_ALU][DEPTH];
  logic [PW-1:0]    wptr_q  [N_ALU];
  logic [PW-1:0]    wptr_d  [N_ALU];
  logic [PW-1:0]    rptr_q  [N_ALU];
  logic [PW-1:0]    rptr_d  [N_ALU];
  logic [CW-1:0]    cnt_q   [N_ALU];
  logic [CW-1:0]    cnt_d   [N_ALU];

  logic [N_ALU-1:0] push_s;
  logic [N_ALU-1:0] pop_s;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    grant_idx_s;
  logic [IW-1:0]    cand_s;
  logic [IW:0]      cand_sum_s;
  logic             hit_s;
  logic             grant_alu_s;
  logic             grant_br_s;

  logic             br_full_q, br_full_d;
  logic [WIDTH-1:0] br_data_q, br_data_d;
  logic [ROB-1:0]   br_rob_q, br_rob_d;
  logic             br_misp_q, br_misp_d;
  logic [WIDTH-1:0] br_tgt_q, br_tgt_d;

  logic             cdb_valid_q, cdb_valid_d;
  logic [WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [ROB-1:0]   cdb_rob_q, cdb_rob_d;
  logic             cdb_redirect_q, cdb_redirect_d;
  logic [WIDTH-1:0] cdb_pc_q, cdb_pc_d;

  assign br_available    = ~br_full_q;
  assign cdb_valid       = cdb_valid_q;
  assign cdb_data        = cdb_data_q;
  assign cdb_rob         = cdb_rob_q;
  assign cdb_redirect    = cdb_redirect_q;
  assign cdb_redirect_pc = cdb_pc_q;

  // Availability comes from stored counts only, so a same-cycle pop never frees a slot early.
  always_comb begin
    for (int i = 0; i < N_ALU; i++) begin
      alu_available[i] = (cnt_q[i] < DEPTH_C);
      push_s[i]        = alu_valid[i] & alu_available[i] & ~flush;
    end
  end

  // Round-robin search from rr; the branch slot overrides any ALU grant.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_idx_s = {IW{1'b0}};
    cand_sum_s  = {(IW + 1){1'b0}};
    cand_s      = {IW{1'b0}};
    hit_s       = 1'b0;
    for (int k = 0; k < N_ALU; k++) begin
      cand_sum_s  = {1'b0, rr_q} + (IW + 1)'(k);
      cand_s      = (cand_sum_s >= N_ALU_C) ? IW'(cand_sum_s - N_ALU_C) : IW'(cand_sum_s);
      hit_s       = ~grant_alu_s & (cnt_q[cand_s] != {CW{1'b0}});
      grant_idx_s = hit_s ? cand_s : grant_idx_s;
      grant_alu_s = grant_alu_s | hit_s;
    end
    grant_br_s  = br_full_q & ~flush;
    grant_alu_s = grant_alu_s & ~br_full_q & ~flush;
    for (int i = 0; i < N_ALU; i++) begin
      pop_s[i] = grant_alu_s & (grant_idx_s == IW'(i));
    end
  end

  // Queue pointer/count/storage next state; flush empties without touching stored data.
  always_comb begin
    qdata_d = qdata_q;
    qrob_d  = qrob_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < N_ALU; i++) begin
      if (flush) begin
        wptr_d[i] = {PW{1'b0}};
        rptr_d[i] = {PW{1'b0}};
        cnt_d[i]  = {CW{1'b0}};
      end else begin
        if (push_s[i]) begin
          qdata_d[i][wptr_q[i]] = alu_result[i*WIDTH +: WIDTH];
          qrob_d[i][wptr_q[i]]  = alu_rob[i*ROB +: ROB];
          wptr_d[i]             = wptr_q[i] + 1'b1;
        end else begin
          wptr_d[i] = wptr_q[i];
        end
        rptr_d[i] = pop_s[i] ? (rptr_q[i] + 1'b1) : rptr_q[i];
        cnt_d[i]  = cnt_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
      end
    end
  end

  // Branch slot: a push only lands when empty, a pop only happens when full.
  always_comb begin
    br_data_d = br_data_q;
    br_rob_d  = br_rob_q;
    br_misp_d = br_misp_q;
    br_tgt_d  = br_tgt_q;
    if (flush) begin
      br_full_d = 1'b0;
    end else if (br_valid & ~br_full_q) begin
      br_full_d = 1'b1;
      br_data_d = br_result;
      br_rob_d  = br_rob;
      br_misp_d = br_mispredict;
      br_tgt_d  = br_target;
    end else if (grant_br_s) begin
      br_full_d = 1'b0;
    end else begin
      br_full_d = br_full_q;
    end
  end

  // Broadcast register; data/tag/pc hold when idle, valid and redirect pulse per grant.
  always_comb begin
    cdb_valid_d    = 1'b0;
    cdb_redirect_d = 1'b0;
    cdb_data_d     = cdb_data_q;
    cdb_rob_d      = cdb_rob_q;
    cdb_pc_d       = cdb_pc_q;
    if (grant_br_s) begin
      cdb_valid_d    = 1'b1;
      cdb_data_d     = br_data_q;
      cdb_rob_d      = br_rob_q;
      cdb_redirect_d = br_misp_q;
      cdb_pc_d       = br_misp_q ? br_tgt_q : cdb_pc_q;
    end else if (grant_alu_s) begin
      cdb_valid_d = 1'b1;
      cdb_data_d  = qdata_q[grant_idx_s][rptr_q[grant_idx_s]];
      cdb_rob_d   = qrob_q[grant_idx_s][rptr_q[grant_idx_s]];
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  // Round-robin pointer advances past the channel that just won.
  always_comb begin
    if (grant_alu_s) begin
      rr_d = (grant_idx_s == LAST_C) ? {IW{1'b0}} : (grant_idx_s + 1'b1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Payload storage carries no reset; validity lives in the counters.
  always_ff @(posedge clk) begin
    qdata_q <= qdata_d;
    qrob_q  <= qrob_d;
  end

  // Control and broadcast state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_ALU; i++) begin
        wptr_q[i] <= {PW{1'b0}};
        rptr_q[i] <= {PW{1'b0}};
        cnt_q[i]  <= {CW{1'b0}};
      end
      rr_q           <= {IW{1'b0}};
      br_full_q      <= 1'b0;
      br_data_q      <= {WIDTH{1'b0}};
      br_rob_q       <= {ROB{1'b0}};
      br_misp_q      <= 1'b0;
      br_tgt_q       <= {WIDTH{1'b0}};
      cdb_valid_q    <= 1'b0;
      cdb_data_q     <= {WIDTH{1'b0}};
      cdb_rob_q      <= {ROB{1'b0}};
      cdb_redirect_q <= 1'b0;
      cdb_pc_q       <= {WIDTH{1'b0}};
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      cnt_q          <= cnt_d;
      rr_q           <= rr_d;
      br_full_q      <= br_full_d;
      br_data_q      <= br_data_d;
      br_rob_q       <= br_rob_d;
      br_misp_q      <= br_misp_d;
      br_tgt_q       <= br_tgt_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_data_q     <= cdb_data_d;
      cdb_rob_q      <= cdb_rob_d;
      cdb_redirect_q <= cdb_redirect_d;
      cdb_pc_q       <= cdb_pc_d;
    end
  end

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Directed bench for fu_cdb_arbiter: hand-computed broadcast sequences for
// priority, round-robin, full queues, mispredict/flush and asynchronous reset.
module tb_fu_cdb_arbiter;
  localparam int WIDTH = 32;
  localparam int ROB   = 3;
  localparam int N_ALU = 2;
  localparam int DEPTH = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [N_ALU-1:0]       alu_valid;
  logic [N_ALU*WIDTH-1:0] alu_result;
  logic [N_ALU*ROB-1:0]   alu_rob;
  logic [N_ALU-1:0]       alu_available;
  logic                   br_valid;
  logic [WIDTH-1:0]       br_result;
  logic [ROB-1:0]         br_rob;
  logic                   br_mispredict;
  logic [WIDTH-1:0]       br_target;
  logic                   br_available;
  logic                   cdb_valid;
  logic [WIDTH-1:0]       cdb_data;
  logic [ROB-1:0]         cdb_rob;
  logic                   cdb_redirect;
  logic [WIDTH-1:0]       cdb_redirect_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] fair_exp [0:5];

  fu_cdb_arbiter #(.WIDTH(WIDTH), .ROB(ROB), .N_ALU(N_ALU), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_rob(alu_rob),
    .alu_available(alu_available),
    .br_valid(br_valid), .br_result(br_result), .br_rob(br_rob),
    .br_mispredict(br_mispredict), .br_target(br_target), .br_available(br_available),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_rob(cdb_rob),
    .cdb_redirect(cdb_redirect), .cdb_redirect_pc(cdb_redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_alu(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [2:0] r0, input logic [2:0] r1);
    alu_valid  = v;
    alu_result = {d1, d0};
    alu_rob    = {r1, r0};
  endtask

  task automatic drive_br(input logic v, input logic [31:0] d, input logic [2:0] r,
                          input logic m, input logic [31:0] t);
    br_valid      = v;
    br_result     = d;
    br_rob        = r;
    br_mispredict = m;
    br_target     = t;
  endtask

  initial begin
    fair_exp[0] = 32'h201; fair_exp[1] = 32'h101; fair_exp[2] = 32'h202;
    fair_exp[3] = 32'h102; fair_exp[4] = 32'h203; fair_exp[5] = 32'h104;
    reset = 1'b1;
    flush = 1'b0;
    drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
    drive_br(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    #2;
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_data", cdb_data, 32'h0);
    chk("rst_redirect", cdb_redirect, 1'b0);
    chk("rst_alu_avail", alu_available, 2'b11);
    chk("rst_br_avail", br_available, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_valid", cdb_valid, 1'b0);

    // contention: branch, then ALU0, then ALU1
    drive_alu(2'b11, 32'hA0, 32'hA1, 3'd1, 3'd3);
    drive_br(1'b1, 32'hB0, 3'd5, 1'b0, 32'h123);
    tick();
    drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
    drive_br(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk("cont_push_valid", cdb_valid, 1'b0);
    chk("cont_alu_avail", alu_available, 2'b11);
    chk("cont_br_avail", br_available, 1'b0);
    tick();
    chk("cont_br_valid", cdb_valid, 1'b1);
    chk("cont_br_data", cdb_data, 32'hB0);
    chk("cont_br_rob", cdb_rob, 3'd5);
    chk("cont_br_redirect", cdb_redirect, 1'b0);
    tick();
    chk("cont_alu0_data", cdb_data, 32'hA0);
    chk("cont_alu0_rob", cdb_rob, 3'd1);
    tick();
    chk("cont_alu1_data", cdb_data, 32'hA1);
    chk("cont_alu1_rob", cdb_rob, 3'd3);
    tick();
    chk("cont_idle_valid", cdb_valid, 1'b0);
    chk("cont_idle_hold", cdb_data, 32'hA1);

    // single push: minimum latency of two edges
    drive_alu(2'b01, 32'h11, 32'h0, 3'd2, 3'd0);
    tick();
    drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
    chk("single_e1_valid", cdb_valid, 1'b0);
    tick();
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_data", cdb_data, 32'h11);
    chk("single_rob", cdb_rob, 3'd2);
    tick();
    chk("single_after_valid", cdb_valid, 1'b0);
    chk("single_after_hold", cdb_data, 32'h11);

    // fairness: rr points at channel 1 here; grants alternate 1,0,1,0,...
    for (int k = 1; k <= 7; k++) begin
      if (k <= 4) drive_alu(2'b11, 32'(32'h100 + k), 32'(32'h200 + k), 3'd0, 3'd0);
      else        drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
      tick();
      if (k == 2) chk("fair_avail_e2", alu_available, 2'b10);
      if (k == 3) chk("fair_avail_e3", alu_available, 2'b01);
      if (k >= 2) begin
        chk("fair_valid", cdb_valid, 1'b1);
        chk("fair_data", cdb_data, fair_exp[k-2]);
      end
    end
    tick();
    chk("fair_idle_valid", cdb_valid, 1'b0);

    // full queue while branch holds the bus; third push is dropped
    drive_alu(2'b01, 32'h301, 32'h0, 3'd1, 3'd0);
    drive_br(1'b1, 32'hB1, 3'd4, 1'b0, 32'h0);
    tick();
    drive_br(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    drive_alu(2'b01, 32'h302, 32'h0, 3'd2, 3'd0);
    chk("full_a_valid", cdb_valid, 1'b0);
    tick();
    chk("full_br_data", cdb_data, 32'hB1);
    chk("full_avail", alu_available, 2'b10);
    drive_alu(2'b01, 32'h303, 32'h0, 3'd3, 3'd0);
    tick();
    drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
    chk("full_d0_data", cdb_data, 32'h301);
    chk("full_d0_rob", cdb_rob, 3'd1);
    chk("full_avail_after", alu_available, 2'b11);
    tick();
    chk("full_d1_data", cdb_data, 32'h302);
    chk("full_d1_rob", cdb_rob, 3'd2);
    tick();
    chk("full_drop_valid", cdb_valid, 1'b0);

    // mispredict broadcast, then flush with entries queued
    drive_br(1'b1, 32'hB2, 3'd6, 1'b1, 32'h400);
    drive_alu(2'b11, 32'h501, 32'h601, 3'd1, 3'd2);
    tick();
    drive_br(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
    tick();
    chk("misp_valid", cdb_valid, 1'b1);
    chk("misp_redirect", cdb_redirect, 1'b1);
    chk("misp_pc", cdb_redirect_pc, 32'h400);
    chk("misp_data", cdb_data, 32'hB2);
    chk("misp_rob", cdb_rob, 3'd6);
    flush = 1'b1;
    drive_alu(2'b11, 32'h5FF, 32'h6FF, 3'd0, 3'd0);
    drive_br(1'b1, 32'hBF, 3'd0, 1'b1, 32'h800);
    tick();
    flush = 1'b0;
    drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
    drive_br(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    chk("flush_valid", cdb_valid, 1'b0);
    chk("flush_redirect", cdb_redirect, 1'b0);
    chk("flush_alu_avail", alu_available, 2'b11);
    chk("flush_br_avail", br_available, 1'b1);
    chk("flush_pc_hold", cdb_redirect_pc, 32'h400);
    tick();
    chk("post_flush_valid", cdb_valid, 1'b0);
    chk("post_flush_redirect", cdb_redirect, 1'b0);

    // asynchronous reset between edges with full queues
    drive_br(1'b1, 32'hB3, 3'd3, 1'b0, 32'h0);
    drive_alu(2'b11, 32'h701, 32'h801, 3'd1, 3'd2);
    tick();
    drive_br(1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    drive_alu(2'b11, 32'h702, 32'h802, 3'd3, 3'd4);
    tick();
    drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
    chk("arst_pre_valid", cdb_valid, 1'b1);
    chk("arst_pre_avail", alu_available, 2'b00);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", cdb_valid, 1'b0);
    chk("arst_data", cdb_data, 32'h0);
    chk("arst_rob", cdb_rob, 3'd0);
    chk("arst_redirect", cdb_redirect, 1'b0);
    chk("arst_pc", cdb_redirect_pc, 32'h0);
    chk("arst_alu_avail", alu_available, 2'b11);
    chk("arst_br_avail", br_available, 1'b1);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_quiet_valid", cdb_valid, 1'b0);
    end
    drive_alu(2'b10, 32'h0, 32'h900, 3'd0, 3'd7);
    tick();
    drive_alu(2'b00, 32'h0, 32'h0, 3'd0, 3'd0);
    tick();
    chk("arst_new_valid", cdb_valid, 1'b1);
    chk("arst_new_data", cdb_data, 32'h900);
    chk("arst_new_rob", cdb_rob, 3'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
